// File: rtl/autoconfig_pkg.sv
// Shared AUTOCONFIG constants: register offsets, config page, Zorro II window, size codes.
// Latency: n/a (constants and a pure helper function).
// Backpressure: n/a.
package autoconfig_pkg;

    // Word offsets (A7:1) inside the $E8xxxx configuration page
    localparam logic [6:0] OFS_TYPE_HI = 7'h00;
    localparam logic [6:0] OFS_TYPE_LO = 7'h01;
    localparam logic [6:0] OFS_PROD_HI = 7'h02;
    localparam logic [6:0] OFS_PROD_LO = 7'h03;
    localparam logic [6:0] OFS_BASE_HI = 7'h24;
    localparam logic [6:0] OFS_BASE_LO = 7'h25;
    localparam logic [6:0] OFS_SHUTUP  = 7'h26;

    localparam logic [7:0] CFG_PAGE  = 8'hE8;
    localparam logic [7:0] ZII_START = 8'h20;
    localparam logic [7:0] ZII_END   = 8'hA0;

    // er_Type[2:0]; code 0 is 8 MB, which cannot fit in the Zorro II window
    typedef enum logic [2:0] {
        SZ_8M   = 3'd0,
        SZ_64K  = 3'd1,
        SZ_128K = 3'd2,
        SZ_256K = 3'd3,
        SZ_512K = 3'd4,
        SZ_1M   = 3'd5,
        SZ_2M   = 3'd6,
        SZ_4M   = 3'd7
    } size_code_t;

    // Board size in 64 KB units; zero for the unplaceable 8 MB code
    function automatic logic [8:0] size_units(input size_code_t code);
        size_units = (code == SZ_8M) ? 9'd0 : (9'd1 << (code - 3'd1));
    endfunction

endpackage

// File: rtl/zorro_bus_cycle.sv
// One Zorro II word bus cycle (read or nibble write) with DTACK timeout.
// Latency: 4 clocks B_ADDR..B_END when DTACK is registered in the first wait clock.
// Backpressure: req is only accepted while idle; ack pulses in B_END, timeout qualifies it.
module zorro_bus_cycle
    import autoconfig_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        MB_CLK,
    input  logic        RESET,
    input  logic        req,
    input  logic        rw,
    input  logic [22:0] addr,
    input  logic [3:0]  wdata,
    output logic        ack,
    output logic        timeout,
    output logic [3:0]  rdata,
    output logic [22:0] host_addr,
    output logic        host_as,
    output logic        host_uds,
    output logic        host_lds,
    output logic        host_rw,
    output logic [3:0]  data_out,
    output logic        data_oe,
    input  logic [3:0]  data_in,
    input  logic        dtack
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {B_IDLE, B_ADDR, B_STROBE, B_WAIT, B_END} bus_state_t;

    bus_state_t    state, state_d;
    logic [CW-1:0] wait_cnt;
    logic          dtack_q;
    logic          tmo_q;
    logic [3:0]    rdata_q;
    logic          strobe_d;

    assign ack      = (state == B_END);
    assign timeout  = tmo_q;
    assign rdata    = rdata_q;
    assign strobe_d = (state_d == B_STROBE) || (state_d == B_WAIT);

    // Next bus phase: fixed address/strobe steps, then wait for DTACK or the timeout
    always_comb begin
        state_d = state;
        case (state)
            B_IDLE:   if (req) state_d = B_ADDR;
            B_ADDR:   state_d = B_STROBE;
            B_STROBE: state_d = B_WAIT;
            B_WAIT:   if (!dtack_q || wait_cnt == CW'(TIMEOUT - 1)) state_d = B_END;
            B_END:    state_d = B_IDLE;
            default:  state_d = B_IDLE;
        endcase
    end

    // Bus phase register plus registered pin drivers; reset forces strobes high and OE low at once
    always_ff @(posedge MB_CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= B_IDLE;
            wait_cnt  <= '0;
            dtack_q   <= 1'b1;
            tmo_q     <= 1'b0;
            rdata_q   <= 4'h0;
            host_addr <= 23'h0;
            host_as   <= 1'b1;
            host_uds  <= 1'b1;
            host_lds  <= 1'b1;
            host_rw   <= 1'b1;
            data_out  <= 4'h0;
            data_oe   <= 1'b0;
        end else begin
            state    <= state_d;
            dtack_q  <= dtack;
            wait_cnt <= (state == B_WAIT) ? wait_cnt + 1'b1 : '0;
            if (state == B_WAIT && state_d == B_END) begin
                tmo_q <= dtack_q;
                if (!dtack_q) rdata_q <= data_in;
            end
            host_as  <= !strobe_d;
            host_uds <= !strobe_d;
            // Nibble writes land on D15:12 only, so LDS stays off for writes
            host_lds <= !(strobe_d && host_rw);
            if (state == B_IDLE && req) begin
                host_addr <= addr;
                host_rw   <= rw;
                data_out  <= wdata;
                data_oe   <= !rw;
            end else if (state_d == B_IDLE) begin
                host_addr <= 23'h0;
                host_rw   <= 1'b1;
                data_out  <= 4'h0;
                data_oe   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/autoconfig_host.sv
// Zorro II AUTOCONFIG initiator: probes $E8 boards, assigns aligned bases or shuts them up.
// Latency: START to HOST_AS low is 3 clocks; one report per board, DONE at chain end.
// Backpressure: START is ignored while BUSY; each step waits on the bus cycle ack.
module autoconfig_host
    import autoconfig_pkg::*;
#(
    parameter int TIMEOUT    = 64,
    parameter int MAX_BOARDS = 8
) (
    input  logic        MB_CLK,
    input  logic        RESET,
    input  logic        START,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [3:0]  BOARD_COUNT,
    output logic        CFG_VALID,
    output logic [7:0]  CFG_BASE,
    output logic [2:0]  CFG_SIZE,
    output logic [7:0]  CFG_PRODUCT,
    output logic        CFG_SHUTUP,
    output logic [22:0] HOST_ADDR,
    output logic        HOST_AS,
    output logic        HOST_UDS,
    output logic        HOST_LDS,
    output logic        HOST_RW,
    output logic [3:0]  DATA_OUT,
    output logic        DATA_OE,
    input  logic [3:0]  DATA_IN,
    input  logic        DTACK
);

    typedef enum logic [2:0] {
        S_IDLE, S_PROBE, S_DECIDE, S_WR_LO, S_WR_HI, S_WR_SHUT, S_REPORT, S_FINISH
    } state_t;

    state_t     state, state_d;
    logic [1:0] probe_idx;
    logic [15:0] nibs;
    logic [7:0] nf;
    logic       err_q;
    logic [3:0] count_q;

    logic       bus_req, bus_rw, bus_ack, bus_tmo;
    logic [6:0] bus_ofs;
    logic [3:0] bus_wdata, bus_rdata;

    size_code_t code;
    logic [8:0] units, nb_calc, end_calc;
    logic       dec_shut;

    assign code        = size_code_t'(nibs[10:8]);
    assign BUSY        = (state != S_IDLE);
    assign DONE        = (state == S_FINISH);
    assign CFG_VALID   = (state == S_REPORT);
    assign ERR         = err_q;
    assign BOARD_COUNT = count_q;

    // Placement: round the free pointer up to the board's natural alignment and test the fit
    always_comb begin
        units    = size_units(code);
        nb_calc  = ({1'b0, nf} + units - 9'd1) & ~(units - 9'd1);
        end_calc = nb_calc + units;
        dec_shut = (nibs[15:14] != 2'b11) || (code == SZ_8M) || (end_calc > {1'b0, ZII_END});
    end

    // Enumeration sequencing and bus request generation
    always_comb begin
        state_d   = state;
        bus_req   = 1'b0;
        bus_rw    = 1'b1;
        bus_ofs   = OFS_TYPE_HI;
        bus_wdata = 4'h0;
        case (state)
            S_IDLE: if (START) state_d = S_PROBE;
            S_PROBE: begin
                bus_req = 1'b1;
                bus_ofs = OFS_TYPE_HI + 7'(probe_idx);
                if (bus_ack) begin
                    if (bus_tmo)                 state_d = S_FINISH;
                    else if (probe_idx == 2'd3)  state_d = S_DECIDE;
                end
            end
            S_DECIDE: state_d = dec_shut ? S_WR_SHUT : S_WR_LO;
            S_WR_LO: begin
                bus_req   = 1'b1;
                bus_rw    = 1'b0;
                bus_ofs   = OFS_BASE_LO;
                bus_wdata = CFG_BASE[3:0];
                if (bus_ack) state_d = bus_tmo ? S_FINISH : S_WR_HI;
            end
            S_WR_HI: begin
                bus_req   = 1'b1;
                bus_rw    = 1'b0;
                bus_ofs   = OFS_BASE_HI;
                bus_wdata = CFG_BASE[7:4];
                if (bus_ack) state_d = bus_tmo ? S_FINISH : S_REPORT;
            end
            S_WR_SHUT: begin
                bus_req = 1'b1;
                bus_rw  = 1'b0;
                bus_ofs = OFS_SHUTUP;
                if (bus_ack) state_d = bus_tmo ? S_FINISH : S_REPORT;
            end
            S_REPORT: state_d = (count_q == 4'(MAX_BOARDS - 1)) ? S_FINISH : S_PROBE;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register and per-board datapath: nibble capture, placement, status
    always_ff @(posedge MB_CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= S_IDLE;
            probe_idx   <= 2'd0;
            nibs        <= 16'h0;
            nf          <= 8'h0;
            err_q       <= 1'b0;
            count_q     <= 4'h0;
            CFG_BASE    <= 8'h0;
            CFG_SIZE    <= 3'h0;
            CFG_PRODUCT <= 8'h0;
            CFG_SHUTUP  <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                S_IDLE: if (START) begin
                    err_q     <= 1'b0;
                    count_q   <= 4'h0;
                    nf        <= ZII_START;
                    probe_idx <= 2'd0;
                end
                S_PROBE: if (bus_ack) begin
                    // Silence on the first read is a normal empty chain, not an error
                    if (bus_tmo) begin
                        if (probe_idx != 2'd0) err_q <= 1'b1;
                    end else begin
                        nibs      <= {nibs[11:0], bus_rdata};
                        probe_idx <= probe_idx + 2'd1;
                    end
                end
                S_DECIDE: begin
                    CFG_SIZE    <= code;
                    CFG_PRODUCT <= ~nibs[7:0];
                    CFG_SHUTUP  <= dec_shut;
                    CFG_BASE    <= dec_shut ? 8'h0 : nb_calc[7:0];
                    if (!dec_shut) nf <= end_calc[7:0];
                end
                S_WR_LO, S_WR_HI, S_WR_SHUT: if (bus_ack && bus_tmo) err_q <= 1'b1;
                S_REPORT: count_q <= count_q + 4'h1;
                default: ;
            endcase
        end
    end

    zorro_bus_cycle #(.TIMEOUT(TIMEOUT)) u_bus (
        .MB_CLK    (MB_CLK),
        .RESET     (RESET),
        .req       (bus_req),
        .rw        (bus_rw),
        .addr      ({CFG_PAGE, 8'h00, bus_ofs}),
        .wdata     (bus_wdata),
        .ack       (bus_ack),
        .timeout   (bus_tmo),
        .rdata     (bus_rdata),
        .host_addr (HOST_ADDR),
        .host_as   (HOST_AS),
        .host_uds  (HOST_UDS),
        .host_lds  (HOST_LDS),
        .host_rw   (HOST_RW),
        .data_out  (DATA_OUT),
        .data_oe   (DATA_OE),
        .data_in   (DATA_IN),
        .dtack     (DTACK)
    );

endmodule

// File: tb/tb_autoconfig_host.sv
// Bench for autoconfig_host: behavioural board chain, placement reference model, scoreboard.
// Latency: checks START->AS, timeout->ERR timing and per-board reports.
// Backpressure: responder acknowledges every cycle unless told to withhold DTACK.
module tb_autoconfig_host;

    localparam int TIMEOUT    = 64;
    localparam int MAX_BOARDS = 8;

    logic        MB_CLK = 1'b0;
    logic        RESET  = 1'b0;
    logic        START  = 1'b0;
    logic        BUSY, DONE, ERR, CFG_VALID, CFG_SHUTUP;
    logic [3:0]  BOARD_COUNT;
    logic [7:0]  CFG_BASE, CFG_PRODUCT;
    logic [2:0]  CFG_SIZE;
    logic [22:0] HOST_ADDR;
    logic        HOST_AS, HOST_UDS, HOST_LDS, HOST_RW, DATA_OE;
    logic [3:0]  DATA_OUT;
    logic [3:0]  DATA_IN = 4'h0;
    logic        DTACK   = 1'b1;

    autoconfig_host #(.TIMEOUT(TIMEOUT), .MAX_BOARDS(MAX_BOARDS)) dut (
        .MB_CLK(MB_CLK), .RESET(RESET), .START(START),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .BOARD_COUNT(BOARD_COUNT),
        .CFG_VALID(CFG_VALID), .CFG_BASE(CFG_BASE), .CFG_SIZE(CFG_SIZE),
        .CFG_PRODUCT(CFG_PRODUCT), .CFG_SHUTUP(CFG_SHUTUP),
        .HOST_ADDR(HOST_ADDR), .HOST_AS(HOST_AS), .HOST_UDS(HOST_UDS),
        .HOST_LDS(HOST_LDS), .HOST_RW(HOST_RW), .DATA_OUT(DATA_OUT),
        .DATA_OE(DATA_OE), .DATA_IN(DATA_IN), .DTACK(DTACK)
    );

    always #5 MB_CLK = ~MB_CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Board chain as seen from the bus: raw er_Type and true product per board
    logic [7:0]  brd_type [16];
    logic [7:0]  brd_prod [16];
    int          n_boards = 0;
    int          rsp_ptr  = 0;
    bit          wh_en    = 1'b0;
    logic [6:0]  wh_ofs   = 7'h0;

    logic [10:0] wlog  [$];   // {offset, nibble} of each acknowledged write
    logic [19:0] rep_q [$];   // {base, size, product, shutup} per CFG_VALID
    int          done_seen = 0;
    int          done_before = 0;
    logic [3:0]  done_cnt = 4'h0;
    logic        done_err = 1'b0;

    logic [19:0] exp_rep [$];
    logic [10:0] exp_wr  [$];
    int          exp_cnt = 0;
    bit          exp_err = 1'b0;

    // Chain responder: current board answers in the $E8 page; a board leaves on completion of its base-high or shutup write
    initial begin
        logic [6:0] ofs;
        logic [7:0] p;
        bit         cyc_acked, cyc_wr, prev_as;
        logic [6:0] cyc_ofs;
        cyc_acked = 0; cyc_wr = 0; prev_as = 1; cyc_ofs = 7'h0;
        forever begin
            @(posedge MB_CLK); #1;
            if (HOST_AS == 1'b0) begin
                ofs = HOST_ADDR[6:0];
                if (rsp_ptr < n_boards && HOST_ADDR[22:7] == 16'hE800 && !(wh_en && ofs == wh_ofs)) begin
                    DTACK = 1'b0;
                    p = ~brd_prod[rsp_ptr];
                    case (ofs)
                        7'h00:   DATA_IN = brd_type[rsp_ptr][7:4];
                        7'h01:   DATA_IN = brd_type[rsp_ptr][3:0];
                        7'h02:   DATA_IN = p[7:4];
                        7'h03:   DATA_IN = p[3:0];
                        default: DATA_IN = 4'h0;
                    endcase
                    if (!HOST_RW && !cyc_acked && DATA_OE) wlog.push_back({ofs, DATA_OUT});
                    cyc_acked = 1; cyc_ofs = ofs; cyc_wr = !HOST_RW;
                end else begin
                    DTACK = 1'b1;
                end
            end else begin
                DTACK = 1'b1;
                if (!prev_as && cyc_acked && cyc_wr && (cyc_ofs == 7'h24 || cyc_ofs == 7'h26))
                    rsp_ptr++;
                cyc_acked = 0;
            end
            prev_as = HOST_AS;
        end
    end

    // Output monitor: records every report and DONE status
    initial begin
        forever begin
            @(negedge MB_CLK);
            if (CFG_VALID) rep_q.push_back({CFG_BASE, CFG_SIZE, CFG_PRODUCT, CFG_SHUTUP});
            if (DONE) begin
                done_seen++;
                done_cnt = BOARD_COUNT;
                done_err = ERR;
            end
        end
    end

    // Reference: first-fit placement at natural alignment in 64 KB units, window $20..$A0
    task automatic build_model();
        int nf, u, base, code;
        bit shut;
        exp_rep.delete(); exp_wr.delete();
        exp_cnt = 0; exp_err = 1'b0; nf = 32; u = 0;
        if (wh_en && wh_ofs >= 7'h01 && wh_ofs <= 7'h03 && n_boards > 0) begin
            exp_err = 1'b1;
            return;
        end
        for (int i = 0; i < n_boards && exp_cnt < MAX_BOARDS; i++) begin
            code = int'(brd_type[i] & 8'h07);
            shut = ((brd_type[i] >> 6) != 8'd3) || (code == 0);
            base = 0;
            if (!shut) begin
                u    = 1 << (code - 1);
                base = ((nf + u - 1) / u) * u;
                if (base + u > 160) begin
                    shut = 1;
                    base = 0;
                end
            end
            if (shut) begin
                exp_wr.push_back({7'h26, 4'h0});
            end else begin
                exp_wr.push_back({7'h25, 4'(base % 16)});
                exp_wr.push_back({7'h24, 4'(base / 16)});
                nf = base + u;
            end
            exp_rep.push_back({8'(base), 3'(code), brd_prod[i], shut});
            exp_cnt++;
        end
    endtask

    task automatic start_chain();
        rep_q.delete(); wlog.delete();
        rsp_ptr = 0;
        build_model();
        done_before = done_seen;
        @(negedge MB_CLK); START = 1'b1;
        @(posedge MB_CLK); #1; START = 1'b0;
    endtask

    task automatic finish_chain(input bit poke);
        int n;
        n = 0;
        if (poke) begin
            repeat (20) @(negedge MB_CLK);
            START = 1'b1;
            @(negedge MB_CLK);
            START = 1'b0;
        end
        while (done_seen == done_before && n < 3000) begin
            @(negedge MB_CLK);
            n++;
        end
        check("done_pulse", done_seen - done_before, 1);
        @(negedge MB_CLK);
        check("done_count", done_cnt, exp_cnt);
        check("done_err", done_err, exp_err);
        check("idle_busy", BUSY, 1'b0);
        check("idle_strobes", {HOST_AS, HOST_UDS, HOST_LDS, DATA_OE}, 4'b1110);
        check("n_cfg", rep_q.size(), exp_rep.size());
        foreach (exp_rep[i])
            if (i < rep_q.size()) check($sformatf("cfg[%0d]", i), rep_q[i], exp_rep[i]);
        check("n_writes", wlog.size(), exp_wr.size());
        foreach (exp_wr[i])
            if (i < wlog.size()) check($sformatf("write[%0d]", i), wlog[i], exp_wr[i]);
    endtask

    initial begin
        int n, k;
        logic [7:0] t;

        repeat (3) @(negedge MB_CLK);
        check("rst_strobes", {HOST_AS, HOST_UDS, HOST_LDS, HOST_RW}, 4'hF);
        check("rst_addr", HOST_ADDR, 23'h0);
        check("rst_oe", DATA_OE, 1'b0);
        check("rst_status", {BUSY, DONE, ERR, CFG_VALID, CFG_SHUTUP}, 5'h0);
        check("rst_count", BOARD_COUNT, 4'h0);
        check("rst_cfg", {CFG_BASE, CFG_SIZE, CFG_PRODUCT}, 19'h0);
        RESET = 1'b1;
        repeat (2) @(negedge MB_CLK);

        // Single 1 MB board: nibbles C,5,9,7 -> base $20, product $68
        n_boards = 1; brd_type[0] = 8'hC5; brd_prod[0] = 8'h68;
        start_chain();
        n = 1;
        while (HOST_AS && n < 10) begin
            @(posedge MB_CLK); #1;
            n++;
        end
        check("start_to_as", n, 3);
        finish_chain(0);
        check("base_1mb", CFG_BASE, 8'h20);
        check("prod_1mb", CFG_PRODUCT, 8'h68);

        // 64 KB then 512 KB
        n_boards = 2; brd_type[0] = 8'hC1; brd_type[1] = 8'hC4;
        brd_prod[0] = 8'h11; brd_prod[1] = 8'h22;
        start_chain(); finish_chain(0);

        // Five 2 MB boards, last is shut up; a START mid-run must be ignored
        n_boards = 5;
        for (int i = 0; i < 5; i++) begin brd_type[i] = 8'hC6; brd_prod[i] = 8'(i + 3); end
        start_chain(); finish_chain(1);
        check("shut_2mb", CFG_SHUTUP, 1'b1);

        // 8 MB and non-Zorro-II types are shut up
        n_boards = 2; brd_type[0] = 8'hC0; brd_type[1] = 8'h45;
        start_chain(); finish_chain(0);

        // More boards than MAX_BOARDS
        n_boards = 10;
        for (int i = 0; i < 10; i++) begin brd_type[i] = 8'hC1; brd_prod[i] = 8'(i * 7); end
        start_chain(); finish_chain(0);

        // DTACK withheld on product-high read
        n_boards = 2; brd_type[0] = 8'hC5; brd_type[1] = 8'hC5;
        wh_en = 1'b1; wh_ofs = 7'h02;
        start_chain();
        n = 0;
        while (HOST_ADDR[6:0] != 7'h02 && n < 200) begin @(negedge MB_CLK); n++; end
        check("addr02_seen", HOST_ADDR[6:0], 7'h02);
        n = 0;
        while (!ERR && n < 200) begin @(negedge MB_CLK); n++; end
        check("err_latency", n, TIMEOUT + 3);
        finish_chain(0);
        wh_en = 1'b0;

        // Reset asserted mid-write while waiting for DTACK
        n_boards = 1; brd_type[0] = 8'hC5; brd_prod[0] = 8'h68;
        wh_en = 1'b1; wh_ofs = 7'h25;
        start_chain();
        n = 0;
        while (!(HOST_AS == 1'b0 && HOST_RW == 1'b0) && n < 500) begin @(negedge MB_CLK); n++; end
        check("wr_strobe_seen", {HOST_AS, HOST_RW}, 2'b00);
        check("wr_oe", DATA_OE, 1'b1);
        @(posedge MB_CLK); @(posedge MB_CLK); #2;
        RESET = 1'b0;
        #1;
        check("rst_async_as", HOST_AS, 1'b1);
        check("rst_async_oe", DATA_OE, 1'b0);
        check("rst_async_busy", BUSY, 1'b0);
        @(negedge MB_CLK);
        RESET = 1'b1; wh_en = 1'b0;
        repeat (2) @(negedge MB_CLK);
        start_chain(); finish_chain(0);

        // Randomized chains
        for (int r = 0; r < 15; r++) begin
            n_boards = $urandom_range(0, 10);
            for (int i = 0; i < n_boards; i++) begin
                k = $urandom_range(0, 9);
                t = 8'($urandom);
                if (k < 7) begin
                    t[7:6] = 2'b11;
                    t[2:0] = 3'($urandom_range(1, 7));
                end else if (k == 7) begin
                    t[7:6] = 2'b11;
                    t[2:0] = 3'd0;
                end else if (t[7:6] == 2'b11) begin
                    t[7:6] = 2'b10;
                end
                brd_type[i] = t;
                brd_prod[i] = 8'($urandom);
            end
            start_chain(); finish_chain(0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
